axis_frame_aligner: RTL
=======================

Name: axis_frame_aligner

Overview:
- Upstream stage placed directly before the mean filter.
- Converts a loosely framed AXI4-Stream pixel source (camera or DMA) into exact FRAME_WIDTH x FRAME_HEIGHT frames with correct tuser and tlast, so the filter's line buffers and output counters never desynchronise.
- Short lines are padded, long lines are truncated, early start-of-frame is absorbed by padding, and beats before the first SOF are dropped.
- Sticky error flags report every correction.

Parameters:
DATA_WIDTH, 8, pixel width in bits
FRAME_WIDTH, 640, pixels per output line
FRAME_HEIGHT, 512, lines per output frame
PAD_VALUE, 0, pixel value inserted when padding (DATA_WIDTH bits)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end-of-line
s_axis_tuser  in  1  input start-of-frame
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  aligned pixel
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  high on pixel FRAME_WIDTH-1 of every line
m_axis_tuser  out  1  high only on pixel (0,0)
m_axis_tready  in  1  downstream ready
err_clr  in  1  synchronous clear of all error flags
err_short_line  out  1  sticky: input tlast before FRAME_WIDTH pixels
err_long_line  out  1  sticky: input line longer than FRAME_WIDTH
err_early_sof  out  1  sticky: tuser arrived mid-frame
err_missing_sof  out  1  sticky: beat after frame end without tuser
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream

Behaviour:
- Reset (async assert, sync deassert usage):
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, all err_*=0, frame_done=0, s_axis_tready=0.
  - Internal: state=WAIT_SOF, hcnt=vcnt=0, output buffer empty.
  - Reset mid-frame discards everything. The next output frame starts only at a fresh input tuser.
- Handshake:
  - Input beat accepted when s_axis_tvalid && s_axis_tready.
  - Output beat transferred when m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid, once high, holds, and data/tlast/tuser stay stable until the transfer.
- Output path: a 2-entry skid buffer.
  - Latency is 1 cycle from input accept to m_axis_tvalid.
  - Full throughput of 1 beat/cycle under continuous ready.
  - Registered ready = buffer not full. No combinational path from m_axis_tready to s_axis_tready.
- Counters:
  - hcnt in 0..FRAME_WIDTH-1, vcnt in 0..FRAME_HEIGHT-1, advancing on each beat pushed into the skid buffer (real or pad).
  - Generated tags: tlast = (hcnt==FRAME_WIDTH-1); tuser = (hcnt==0 && vcnt==0).
  - Input tlast and tuser never pass through directly.
- WAIT_SOF:
  - s_axis_tready = buffer not full.
  - Beats without tuser are discarded.
  - A beat with tuser is pushed as pixel (0,0), then go to ACTIVE.
- ACTIVE: each accepted beat is pushed, with these cases:
  - tlast with hcnt<FRAME_WIDTH-1: push the beat, set err_short_line, go to PAD_LINE.
  - hcnt==FRAME_WIDTH-1 and no tlast: push the beat (tagged tlast), set err_long_line, go to DROP_LINE.
  - tuser with (hcnt,vcnt)!=(0,0): do not accept it (tready=0 that cycle), set err_early_sof, go to PAD_FRAME. The tuser beat stays pending at the input.
  - Last pixel of frame (hcnt==FRAME_WIDTH-1, vcnt==FRAME_HEIGHT-1): go to FRAME_END.
- PAD_LINE:
  - s_axis_tready=0; push PAD_VALUE each cycle the buffer is not full.
  - After the pad at hcnt==FRAME_WIDTH-1, go to ACTIVE, or to FRAME_END if that was the last line.
- DROP_LINE:
  - s_axis_tready=1; discard beats up to and including the tlast beat, then go to ACTIVE, or to FRAME_END if the frame is complete.
  - A tuser beat seen in DROP_LINE ends the drop without being accepted and takes the early-SOF path.
- PAD_FRAME:
  - s_axis_tready=0; push PAD_VALUE until the frame's final pixel, then go to ACTIVE at (0,0).
  - The pending tuser beat is then accepted as the new pixel (0,0).
- FRAME_END:
  - Next beat with tuser: push it as (0,0), go to ACTIVE.
  - Next beat without tuser: discard it, set err_missing_sof, go to WAIT_SOF.
- frame_done pulses on the output transfer whose tlast=1 and which is the last line.
- err_* flags are set on event and cleared by err_clr. If a set event and err_clr occur in the same cycle, set wins.
- Simultaneous tlast and tuser on one beat: tuser handling takes priority.

Decomposition:
- Package mf_pkg:
  - state enum: WAIT_SOF, ACTIVE, PAD_LINE, DROP_LINE, PAD_FRAME, FRAME_END.
  - Counter-width localparams derived via $clog2 of FRAME_WIDTH and FRAME_HEIGHT.
  - This package is shared with the mean filter output counters.
- Sub-module: axis_skid_buffer (DATA_WIDTH+2 bits wide, 2 entries). It is reusable at the filter output.

Test Plan:
- W=8,H=4, clean 32-beat frame, continuous ready -> 32 outputs identical to input, tuser on beat 0, tlast on beats 7/15/23/31, frame_done once, no errors.
- Line 1 ends after 5 pixels (tlast on 5th) -> 3 PAD_VALUE pixels output at hcnt 5..7 with tlast on hcnt 7, err_short_line=1, frame total still 32.
- Line 2 carries 11 pixels -> first 8 output with tlast on the 8th, 3 dropped, err_long_line=1, next line aligned at hcnt 0.
- tuser at pixel (3,2) -> remaining 13 pixels padded with PAD_VALUE, err_early_sof=1, new frame starts with that beat tagged tuser.
- 10 beats before the first tuser, then a frame with random m_axis_tready (50%) -> the 10 beats are dropped, output stays stable while stalled, no loss, order preserved.
- rst_n low during line 2 then released -> all outputs 0 immediately; a following input without tuser is dropped until the next tuser.

Source files
------------

// File: rtl/mf_pkg.sv
// Shared definitions for the frame aligner and the mean filter counters.
package mf_pkg;

  // Frame aligner control states.
  typedef enum logic [2:0] {
    WAIT_SOF  = 3'd0,
    ACTIVE    = 3'd1,
    PAD_LINE  = 3'd2,
    DROP_LINE = 3'd3,
    PAD_FRAME = 3'd4,
    FRAME_END = 3'd5
  } state_e;

  // Default frame geometry and the counter widths it implies.
  localparam int MF_FRAME_WIDTH  = 640;
  localparam int MF_FRAME_HEIGHT = 512;
  localparam int MF_HCNT_W = (MF_FRAME_WIDTH  > 1) ? $clog2(MF_FRAME_WIDTH)  : 1;
  localparam int MF_VCNT_W = (MF_FRAME_HEIGHT > 1) ? $clog2(MF_FRAME_HEIGHT) : 1;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer. Entry 0 drives the output directly,
// entry 1 catches the beat that arrives while the output is stalled.
// in_ready is the inverse of the entry-1 valid flop, so it never depends
// combinationally on out_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic             vld0_q, vld0_d;
  logic             vld1_q, vld1_d;
  logic             push_s;
  logic             pop_s;

  // Next-state of the two entries from the push/pop combination.
  always_comb begin
    push_s = in_valid && !vld1_q;
    pop_s  = vld0_q && out_ready;
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    case ({push_s, pop_s})
      2'b01: begin
        mem0_d = mem1_q;
        vld0_d = vld1_q;
        vld1_d = 1'b0;
      end
      2'b10: begin
        if (!vld0_q) begin
          mem0_d = in_data;
          vld0_d = 1'b1;
        end else begin
          mem1_d = in_data;
          vld1_d = 1'b1;
        end
      end
      2'b11: begin
        // Push implies entry 1 is empty, so the new beat replaces the popped head.
        mem0_d = in_data;
      end
      default: begin
        mem0_d = mem0_q;
      end
    endcase
  end

  // Entry storage and valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= {WIDTH{1'b0}};
      mem1_q <= {WIDTH{1'b0}};
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
    end
  end

  assign in_ready  = !vld1_q;
  assign out_data  = mem0_q;
  assign out_valid = vld0_q;

endmodule

// File: rtl/axis_frame_aligner.sv
// Forces a loosely framed pixel stream into exact FRAME_WIDTH x FRAME_HEIGHT
// frames: pads short lines, truncates long lines, pads out frames cut short
// by an early start-of-frame and drops beats until the first start-of-frame.
// Output tags are generated from the internal counters, never forwarded.
module axis_frame_aligner #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    FRAME_WIDTH  = 640,
  parameter int                    FRAME_HEIGHT = 512,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  input  logic                  err_clr,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_early_sof,
  output logic                  err_missing_sof,
  output logic                  frame_done
);

  import mf_pkg::*;

  localparam int HCNT_W = cnt_width(FRAME_WIDTH);
  localparam int VCNT_W = cnt_width(FRAME_HEIGHT);
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(FRAME_WIDTH - 1);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(FRAME_HEIGHT - 1);
  localparam int BUF_W = DATA_WIDTH + 2;

  state_e              state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic [VCNT_W-1:0]   oline_q, oline_d;
  logic                run_q;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                err_early_q, err_early_d;
  logic                err_missing_q, err_missing_d;
  logic                frame_done_q, frame_done_d;

  logic                line_end_s, last_line_s, at_origin_s;
  logic                take_real_s, pad_s, push_s, s_ready_s;
  logic                real_short_s, real_long_s;
  state_e              real_next_s;
  logic                set_early_s, set_missing_s;
  logic                buf_ready_s;
  logic [BUF_W-1:0]    buf_in_s, buf_out_s;
  logic                out_valid_s, xfer_s;

  assign line_end_s  = (hcnt_q == H_LAST);
  assign last_line_s = (vcnt_q == V_LAST);
  assign at_origin_s = (hcnt_q == {HCNT_W{1'b0}}) && (vcnt_q == {VCNT_W{1'b0}});

  // Where a real input pixel pushed at the current position leads.
  always_comb begin
    real_next_s  = ACTIVE;
    real_short_s = 1'b0;
    real_long_s  = 1'b0;
    if (line_end_s) begin
      if (!s_axis_tlast) begin
        real_long_s = 1'b1;
        real_next_s = DROP_LINE;
      end else if (last_line_s) begin
        real_next_s = FRAME_END;
      end else begin
        real_next_s = ACTIVE;
      end
    end else if (s_axis_tlast) begin
      real_short_s = 1'b1;
      real_next_s  = PAD_LINE;
    end else begin
      real_next_s = ACTIVE;
    end
  end

  // Control state machine: input ready, pushes and error events.
  always_comb begin
    state_d       = state_q;
    take_real_s   = 1'b0;
    pad_s         = 1'b0;
    s_ready_s     = 1'b0;
    set_early_s   = 1'b0;
    set_missing_s = 1'b0;
    if (run_q) begin
      case (state_q)
        WAIT_SOF: begin
          s_ready_s = buf_ready_s;
          if (s_axis_tvalid && buf_ready_s && s_axis_tuser) begin
            take_real_s = 1'b1;
            state_d     = real_next_s;
          end else begin
            state_d = WAIT_SOF;
          end
        end
        ACTIVE: begin
          if (s_axis_tvalid && s_axis_tuser && !at_origin_s) begin
            // Hold the new-frame beat at the input until this frame is padded out.
            set_early_s = 1'b1;
            state_d     = PAD_FRAME;
          end else begin
            s_ready_s = buf_ready_s;
            if (s_axis_tvalid && buf_ready_s) begin
              take_real_s = 1'b1;
              state_d     = real_next_s;
            end else begin
              state_d = ACTIVE;
            end
          end
        end
        PAD_LINE: begin
          if (buf_ready_s) begin
            pad_s = 1'b1;
            if (line_end_s) begin
              state_d = last_line_s ? FRAME_END : ACTIVE;
            end else begin
              state_d = PAD_LINE;
            end
          end else begin
            state_d = PAD_LINE;
          end
        end
        DROP_LINE: begin
          if (s_axis_tvalid && s_axis_tuser) begin
            // A completed frame just means the new frame starts cleanly.
            if (at_origin_s) begin
              state_d = ACTIVE;
            end else begin
              set_early_s = 1'b1;
              state_d     = PAD_FRAME;
            end
          end else begin
            s_ready_s = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
              state_d = at_origin_s ? FRAME_END : ACTIVE;
            end else begin
              state_d = DROP_LINE;
            end
          end
        end
        PAD_FRAME: begin
          if (buf_ready_s) begin
            pad_s = 1'b1;
            if (line_end_s && last_line_s) begin
              state_d = ACTIVE;
            end else begin
              state_d = PAD_FRAME;
            end
          end else begin
            state_d = PAD_FRAME;
          end
        end
        FRAME_END: begin
          s_ready_s = buf_ready_s;
          if (s_axis_tvalid && buf_ready_s) begin
            if (s_axis_tuser) begin
              take_real_s = 1'b1;
              state_d     = real_next_s;
            end else begin
              set_missing_s = 1'b1;
              state_d       = WAIT_SOF;
            end
          end else begin
            state_d = FRAME_END;
          end
        end
        default: begin
          state_d = WAIT_SOF;
        end
      endcase
    end else begin
      state_d = WAIT_SOF;
    end
  end

  assign push_s   = take_real_s || pad_s;
  assign buf_in_s = {(pad_s ? PAD_VALUE : s_axis_tdata), line_end_s, at_origin_s};

  // Position counters advance on every pushed beat, real or pad.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (push_s) begin
      if (line_end_s) begin
        hcnt_d = {HCNT_W{1'b0}};
        vcnt_d = last_line_s ? {VCNT_W{1'b0}} : (vcnt_q + VCNT_W'(1));
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Sticky error flags (a set event beats a simultaneous clear) and the
  // output-side line count that locates the final pixel of each frame.
  always_comb begin
    err_short_d   = (take_real_s && real_short_s) || (err_short_q   && !err_clr);
    err_long_d    = (take_real_s && real_long_s)  || (err_long_q    && !err_clr);
    err_early_d   = set_early_s                   || (err_early_q   && !err_clr);
    err_missing_d = set_missing_s                 || (err_missing_q && !err_clr);
    frame_done_d  = 1'b0;
    oline_d       = oline_q;
    if (xfer_s && buf_out_s[1]) begin
      if (oline_q == V_LAST) begin
        oline_d      = {VCNT_W{1'b0}};
        frame_done_d = 1'b1;
      end else begin
        oline_d = oline_q + VCNT_W'(1);
      end
    end else begin
      oline_d = oline_q;
    end
  end

  // State, counters, flags and the ready-enable that keeps the input closed in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SOF;
      hcnt_q        <= {HCNT_W{1'b0}};
      vcnt_q        <= {VCNT_W{1'b0}};
      oline_q       <= {VCNT_W{1'b0}};
      run_q         <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      oline_q       <= oline_d;
      run_q         <= 1'b1;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      frame_done_q  <= frame_done_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (buf_in_s),
    .in_valid (push_s),
    .in_ready (buf_ready_s),
    .out_data (buf_out_s),
    .out_valid(out_valid_s),
    .out_ready(m_axis_tready)
  );

  assign xfer_s          = out_valid_s && m_axis_tready;
  assign s_axis_tready   = s_ready_s;
  assign m_axis_tvalid   = out_valid_s;
  assign m_axis_tdata    = buf_out_s[BUF_W-1:2];
  assign m_axis_tlast    = buf_out_s[1];
  assign m_axis_tuser    = buf_out_s[0];
  assign err_short_line  = err_short_q;
  assign err_long_line   = err_long_q;
  assign err_early_sof   = err_early_q;
  assign err_missing_sof = err_missing_q;
  assign frame_done      = frame_done_q;

endmodule
